// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: ORA state encoding,
// default MISR taps and the pattern counter width.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMPARE,
    DONE
  } state_e;

  localparam int unsigned MISR_POLY_DEF = 32'h1D;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register with seed load,
// compaction enable and parallel response input.
module lbist_misr #(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(32'h1D),
  parameter logic [W-1:0] SEED = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;
  logic         msb;

  assign msb   = sig_q[W-1];
  assign sig_o = sig_q;

  // Stage 0 always takes feedback; POLY[0] is ignored.
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d[0] = msb ^ data_i[0];
      for (int i = 1; i < W; i++) begin
        sig_d[i] = sig_q[i-1]
                 ^ (POLY[i] & msb)
                 ^ data_i[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= SEED;
    else     sig_q <= sig_d;
  end

endmodule

// File: rtl/lbist_ora.sv
// LBIST output response analyzer: MISR compaction, pattern count, golden compare.
// Optional response masking via macro LBIST_ORA_XMASK_EN.
module lbist_ora
  import lbist_pkg::*;
#(
  parameter int               POS_W      = 239,
  parameter int               N_PATTERNS = 1024,
  parameter logic [POS_W-1:0] MISR_POLY  = POS_W'(MISR_POLY_DEF),
  parameter logic [POS_W-1:0] MISR_SEED  = '0,
  parameter logic [POS_W-1:0] GOLDEN_SIG = '0,
  parameter logic [POS_W-1:0] XMASK      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             test_over,
  output logic             go_nogo,
  output logic [POS_W-1:0] signature
);

  localparam int CNT_W = cnt_width(N_PATTERNS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS - 1);

  if (N_PATTERNS < 1) begin : g_bad_n
    $error("N_PATTERNS must be >= 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_q, go_d;
  logic             load, step;
  logic [POS_W-1:0] pos_m;

`ifdef LBIST_ORA_XMASK_EN
  assign pos_m = pos & ~XMASK;
`else
  assign pos_m = pos;
  // Mask is only meaningful when masking is compiled in.
  if (XMASK != '0) begin : g_xmask_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_d    = go_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          go_d    = 1'b0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (resp_valid) begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = COMPARE;
        end
      end
      COMPARE: begin
        go_d    = (signature == GOLDEN_SIG);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == COMPARE);
  assign test_over = (state_q == DONE);
  assign go_nogo   = go_q;

  lbist_misr #(
    .W    (POS_W),
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .en_i   (step),
    .data_i (pos_m),
    .sig_o  (signature)
  );

endmodule

// File: tb/tb_lbist_ora.sv
// Self-checking bench for lbist_ora: directed and random runs
// against an arithmetic MISR reference model.
module tb_lbist_ora;

  localparam int         W    = 8;
  localparam logic [7:0] POLY = 8'h1D;
  localparam logic [7:0] SEED = 8'h00;
  localparam logic [7:0] GOLD = 8'h08;
  localparam logic [7:0] XM   = 8'h01;

  logic       clk = 1'b0;
  logic       rst, start, resp_valid;
  logic [7:0] pos;
  logic       busy, test_over, go_nogo;
  logic [7:0] signature;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model;

  always #5 clk = ~clk;

  lbist_ora #(
    .POS_W      (W),
    .N_PATTERNS (4),
    .MISR_POLY  (POLY),
    .MISR_SEED  (SEED),
    .GOLDEN_SIG (GOLD),
    .XMASK      (XM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_valid (resp_valid),
    .pos        (pos),
    .busy       (busy),
    .test_over  (test_over),
    .go_nogo    (go_nogo),
    .signature  (signature)
  );

  // Signature as polynomial arithmetic: shift left, reduce by
  // POLY (with the implicit x^0 term) on carry-out, add response.
  function automatic logic [7:0] mstep(
    input logic [7:0] s, input logic [7:0] d);
    logic [7:0] dm;
`ifdef LBIST_ORA_XMASK_EN
    dm = d & ~XM;
`else
    dm = d;
`endif
    return ((s << 1) & 8'hFF)
         ^ (s[7] ? (POLY | 8'h01) : 8'h00)
         ^ dm;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] p [4],
                     input int gap,
                     input bit rnd_gap,
                     input bit mid_start);
    int g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model = SEED;
    chk("busy_start", {7'd0, busy}, 8'd1);
    chk("sig_seed", signature, model);
    for (int k = 0; k < 4; k++) begin
      resp_valid = 1'b1;
      pos = p[k];
      @(negedge clk);
      resp_valid = 1'b0;
      pos = 8'($urandom);
      model = mstep(model, p[k]);
      chk($sformatf("sig_v%0d", k), signature, model);
      g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
      if (k < 3) begin
        for (int j = 0; j < g; j++) begin
          if (mid_start && j == 0) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          chk("busy_gap", {7'd0, busy}, 8'd1);
          chk("sig_gap", signature, model);
        end
      end
    end
    chk("over_cmp", {7'd0, test_over}, 8'd0);
    chk("busy_cmp", {7'd0, busy}, 8'd1);
    @(negedge clk);
    chk("over_done", {7'd0, test_over}, 8'd1);
    chk("busy_done", {7'd0, busy}, 8'd0);
    chk("go_nogo", {7'd0, go_nogo}, {7'd0, model == GOLD});
    chk("sig_done", signature, model);
    resp_valid = 1'b1;
    pos = 8'hFF;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("sig_frozen", signature, model);
    chk("over_hold", {7'd0, test_over}, 8'd1);
  endtask

  initial begin
    logic [7:0] pa [4];
    logic [7:0] pf [4];
    logic [7:0] pz [4];
    logic [7:0] pr [4];
    pa = '{8'h01, 8'h00, 8'h00, 8'h00};
    pf = '{8'h80, 8'h00, 8'h00, 8'h00};
    pz = '{8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b0;
    start = 1'b0;
    resp_valid = 1'b0;
    pos = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_over", {7'd0, test_over}, 8'd0);
    chk("rst_go", {7'd0, go_nogo}, 8'd0);
    chk("rst_sig", signature, SEED);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(pa, 0, 1'b0, 1'b0);
`ifndef LBIST_ORA_XMASK_EN
    chk("pass_sig_abs", signature, 8'h08);
    chk("pass_go_abs", {7'd0, go_nogo}, 8'd1);
`endif
    run(pf, 0, 1'b0, 1'b0);
    chk("fb_sig_abs", signature, 8'h74);
    run(pz, 0, 1'b0, 1'b0);
    chk("fail_go_abs", {7'd0, go_nogo}, 8'd0);
    run(pa, 3, 1'b0, 1'b1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_valid = 1'b1;
      pos = 8'h5A;
      @(negedge clk);
      resp_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", {7'd0, busy}, 8'd0);
    chk("mid_over", {7'd0, test_over}, 8'd0);
    chk("mid_go", {7'd0, go_nogo}, 8'd0);
    chk("mid_sig", signature, SEED);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    run(pa, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) pr[k] = 8'($urandom);
      run(pr, 2, 1'b1, r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbist_ora.md
Name: lbist_ora

Overview:
- LBIST output response analyzer. It is the receiving end of the pattern path: the pattern generator drives CUT inputs, and this block consumes the CUT primary outputs (pos).
- Compacts each captured response into a multiple-input signature register (MISR) and counts patterns.
- After the programmed pattern count, compares the signature against a golden value and reports go/no-go to the LBIST controller.

Parameters:
- POS_W, 239, width of CUT response bus and of the MISR.
- N_PATTERNS, 1024, responses compacted per test (>=1).
- MISR_POLY, {POS_W{1'b0}} | 'h1D, feedback taps; bit i set means tap into stage i; bit 0 is ignored (stage 0 always takes feedback).
- MISR_SEED, 0, signature value loaded on start.
- GOLDEN_SIG, 0, expected final signature.
- XMASK, 0, bit set means the response bit is forced to 0 before compaction (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a test.
- resp_valid  in  1  pos is a valid captured response this cycle.
- pos  in  POS_W  CUT response.
- busy  out  1  high in RUN and COMPARE.
- test_over  out  1  high in DONE, held until the next start.
- go_nogo  out  1  1 = signature matched; valid only while test_over=1.
- signature  out  POS_W  current MISR contents.

Behaviour:
- Reset (async, rst=1): state=IDLE, MISR=MISR_SEED, count=0, busy=0, test_over=0, go_nogo=0.
- States: IDLE, RUN, COMPARE, DONE.
- IDLE/DONE + start: next cycle state=RUN, MISR<=MISR_SEED, count<=0, test_over<=0, go_nogo<=0.
- start while in RUN or COMPARE is ignored.
- RUN:
  - On each cycle with resp_valid=1, MISR<=misr_next(pos_m) and count<=count+1.
  - resp_valid=0 holds the MISR and count; gaps are allowed.
  - When a valid arrives with count==N_PATTERNS-1, the last response is compacted and state<=COMPARE.
- COMPARE: one cycle. go_nogo<=(MISR==GOLDEN_SIG), state<=DONE. resp_valid is ignored.
- DONE: test_over=1, busy=0, MISR frozen. resp_valid is ignored.
- MISR update (msb = MISR[POS_W-1]):
  - next[0] = msb ^ pos_m[0].
  - next[i] = MISR[i-1] ^ (MISR_POLY[i] & msb) ^ pos_m[i], for i >= 1.
- pos_m = pos, or pos & ~XMASK when the optional feature is enabled.
- Counter width is clog2(N_PATTERNS+1); it never wraps. N_PATTERNS=1 means a single valid moves the block to COMPARE.
- Latency: from the last valid response, test_over rises 2 cycles later (RUN -> COMPARE -> DONE).
- rst asserted mid-test: immediate return to reset values; no partial result is reported.

Optional Feature:
- Macro LBIST_ORA_XMASK_EN.
- Defined: pos is ANDed with ~XMASK before compaction, so unknown-prone CUT outputs cannot corrupt the signature.
- Undefined: XMASK is unused, pos_m=pos, and no masking logic is synthesized.

Decomposition:
- Package lbist_pkg holds:
  - the state enum (IDLE/RUN/COMPARE/DONE);
  - the default MISR polynomial constant;
  - a clog2-based counter-width function shared with the pattern generator.
- One sub-module, lbist_misr: parameterized MISR register with load (seed), enable, and data inputs. The top level holds the FSM, the counter and the comparator.

Test Plan:
All scenarios use POS_W=8, N_PATTERNS=4, MISR_POLY=8'h1D, MISR_SEED=0.
- Pass, GOLDEN_SIG=8'h08: start, then valid pos 01,00,00,00 -> signature 01,02,04,08; test_over=1 two cycles after the 4th valid; go_nogo=1.
- Feedback, GOLDEN_SIG=8'h74: pos 80,00,00,00 -> signature 80,1D,3A,74; go_nogo=1.
- Fail, GOLDEN_SIG=8'h08: pos 00,00,00,00 -> signature 00; test_over=1, go_nogo=0.
- Gapped valids: the pass stimulus with 3 idle cycles between each valid -> identical signature 08 and go_nogo=1; busy stays 1 throughout the gaps; an extra start mid-RUN has no effect.
- Reset mid-RUN: assert rst after 2 valids -> busy=0, test_over=0, go_nogo=0 and signature=00 immediately. A fresh start with the pass stimulus then passes.
- XMASK, XMASK=8'h01, GOLDEN_SIG=8'h08, pos 01,00,00,00:
  - with LBIST_ORA_XMASK_EN defined: signature 00, go_nogo=0;
  - without it: signature 08, go_nogo=1.
